// File: rtl/pll_dphase_ctrl_if.sv
// Phase-shift request handshake plus completion status for pll_dphase_ctrl.
interface pll_dphase_ctrl_if #(
  parameter int unsigned CW = 8
) ();
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_chan;
  logic          req_dir;
  logic [CW-1:0] req_count;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output req_valid, req_chan, req_dir, req_count,
    input  req_ready, busy, done, err
  );

  modport slave (
    input  req_valid, req_chan, req_dir, req_count,
    output req_ready, busy, done, err
  );
endinterface

// File: rtl/pll_dphase_ctrl.sv
// Sequences PLL dynamic-phase pins (phasesel/phasedir/phasestep) for a requested number of
// steps and tracks each output's phase position modulo PHASE_STEPS.
module pll_dphase_ctrl #(
  parameter int unsigned N_OUT        = 3,
  parameter int unsigned PHASE_STEPS  = 16,
  parameter int unsigned SETUP        = 2,
  parameter int unsigned STEP_LO      = 4,
  parameter int unsigned STEP_HI      = 4,
  parameter int unsigned LOCK_TIMEOUT = 100,
  parameter int unsigned CW           = 8,
  localparam int unsigned PW = (PHASE_STEPS > 1) ? $clog2(PHASE_STEPS) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  pll_dphase_ctrl_if.slave     req_if,
  input  logic                 pll_locked_i,
  output logic [1:0]           phasesel_o,
  output logic                 phasedir_o,
  output logic                 phasestep_o,
  output logic                 phaseloadreg_o,
  output logic [N_OUT*PW-1:0]  phase_pos_o
);

  localparam int unsigned TMaxA = (SETUP > STEP_LO) ? SETUP : STEP_LO;
  localparam int unsigned TMaxB = (STEP_HI > LOCK_TIMEOUT) ? STEP_HI : LOCK_TIMEOUT;
  localparam int unsigned TMax  = (TMaxA > TMaxB) ? TMaxA : TMaxB;
  localparam int unsigned TW    = $clog2(TMax + 1);
  localparam logic [2:0]  NOut  = 3'(N_OUT);

  typedef enum logic [2:0] {
    StIdle, StSetup, StStepLo, StStepHi, StWaitLock, StReport
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] steps_q, steps_d;
  logic [1:0]    chan_q, chan_d;
  logic          dir_q, dir_d;
  logic [PW-1:0] pos_q [N_OUT];
  logic [PW-1:0] pos_d [N_OUT];
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          step_q, step_d;
  logic          load_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    steps_d = steps_q;
    chan_d  = chan_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_if.req_valid && ready_q) begin
          chan_d  = req_if.req_chan;
          dir_d   = req_if.req_dir;
          steps_d = req_if.req_count;
          tmr_d   = '0;
          if (({1'b0, req_if.req_chan} >= NOut) || !pll_locked_i) begin
            state_d = StReport;
            err_d   = 1'b1;
          end else if (req_if.req_count == '0) begin
            state_d = StReport;
            done_d  = 1'b1;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StSetup: begin
        if (!pll_locked_i) begin
          state_d = StReport;
          err_d   = 1'b1;
        end else if (tmr_q == TW'(SETUP - 1)) begin
          state_d = StStepLo;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StStepLo: begin
        // A low phase cut short by lock loss never reaches the position update.
        if (!pll_locked_i) begin
          state_d = StReport;
          err_d   = 1'b1;
        end else if (tmr_q == TW'(STEP_LO - 1)) begin
          state_d = StStepHi;
          tmr_d   = '0;
          for (int i = 0; i < N_OUT; i++) begin
            if (chan_q == 2'(i)) begin
              if (dir_q) begin
                pos_d[i] = (pos_q[i] == '0) ? PW'(PHASE_STEPS - 1) : pos_q[i] - PW'(1);
              end else begin
                pos_d[i] = (pos_q[i] == PW'(PHASE_STEPS - 1)) ? '0 : pos_q[i] + PW'(1);
              end
            end
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StStepHi: begin
        if (!pll_locked_i) begin
          state_d = StReport;
          err_d   = 1'b1;
        end else if (tmr_q == TW'(STEP_HI - 1)) begin
          tmr_d = '0;
          if (steps_q == CW'(1)) begin
            state_d = StWaitLock;
          end else begin
            steps_d = steps_q - CW'(1);
            state_d = StStepLo;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StWaitLock: begin
        if (pll_locked_i) begin
          state_d = StReport;
          done_d  = 1'b1;
        end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
          state_d = StReport;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  assign ready_d = (state_d == StIdle);
  assign busy_d  = (state_d != StIdle);
  assign step_d  = (state_d != StStepLo);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      steps_q <= '0;
      chan_q  <= '0;
      dir_q   <= 1'b0;
      pos_q   <= '{default: '0};
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      step_q  <= 1'b1;
      load_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      steps_q <= steps_d;
      chan_q  <= chan_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      step_q  <= step_d;
      load_q  <= 1'b1;
    end
  end

  assign req_if.req_ready = ready_q;
  assign req_if.busy      = busy_q;
  assign req_if.done      = done_q;
  assign req_if.err       = err_q;
  assign phasesel_o       = chan_q;
  assign phasedir_o       = dir_q;
  assign phasestep_o      = step_q;
  assign phaseloadreg_o   = load_q;

  for (genvar g = 0; g < N_OUT; g++) begin : g_pos
    assign phase_pos_o[g*PW +: PW] = pos_q[g];
  end

endmodule

// File: tb/tb_pll_dphase_ctrl.sv
// Directed bench for pll_dphase_ctrl: per-cycle traces of each request compared to
// hand-derived windows for phasestep, done, err, busy and req_ready.
module tb_pll_dphase_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        locked = 1'b1;
  logic [1:0]  sel;
  logic        dir;
  logic        step;
  logic        load;
  logic [11:0] pos;

  int checks = 0;
  int errors = 0;

  logic [127:0] ps_v, dn_v, er_v, by_v, rd_v;
  logic [3:0]   pos_h [128];
  logic [1:0]   sel1;
  logic         dir1;

  pll_dphase_ctrl_if #(.CW(8)) bus ();

  pll_dphase_ctrl #(
    .N_OUT(3), .PHASE_STEPS(16), .SETUP(2), .STEP_LO(4), .STEP_HI(4),
    .LOCK_TIMEOUT(100), .CW(8)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_if         (bus),
    .pll_locked_i   (locked),
    .phasesel_o     (sel),
    .phasedir_o     (dir),
    .phasestep_o    (step),
    .phaseloadreg_o (load),
    .phase_pos_o    (pos)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Accepts one request in cycle T (bit 0) and records cycles T..T+n.
  task automatic run_req(input logic [1:0] chan, input logic d, input logic [7:0] cnt,
                         input int n, input int drop_at, input int reset_at,
                         input int valid_cycles);
    int tries;
    int base;
    ps_v = '0; dn_v = '0; er_v = '0; by_v = '0; rd_v = '0;
    base = int'(chan) * 4;
    @(posedge clk); #1;
    tries = 0;
    while (bus.req_ready !== 1'b1 && tries < 200) begin
      @(posedge clk); #1;
      tries++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: req_ready=%b after %0d cycles, want 1", bus.req_ready, tries);
    end
    if (drop_at == 0) locked = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_chan  = chan;
    bus.req_dir   = d;
    bus.req_count = cnt;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == valid_cycles) bus.req_valid = 1'b0;
        if (k == drop_at) locked = 1'b0;
        if (k == reset_at) reset = 1'b1;
        if (k == reset_at + 1) reset = 1'b0;
      end
      @(negedge clk);
      ps_v[k] = step;
      dn_v[k] = bus.done;
      er_v[k] = bus.err;
      by_v[k] = bus.busy;
      rd_v[k] = bus.req_ready;
      pos_h[k] = (chan < 2'd3) ? pos[base +: 4] : 4'hx;
      if (k == 1) begin
        sel1 = sel;
        dir1 = dir;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    locked = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_chan = 2'd1;
    bus.req_dir = 1'b1;
    bus.req_count = 8'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
    checks++; if (step !== 1'b1) begin errors++; $display("FAIL rst_phasestep: got %b want 1", step); end
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL rst_phaseloadreg: got %b want 1", load); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rst_phasedir: got %b want 0", dir); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rst_phasesel: got %0d want 0", sel); end
    checks++; if (pos !== 12'h000) begin errors++; $display("FAIL rst_pos: got %h want 000", pos); end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_normal();
    logic [127:0] e_ps;
    run_req(2'd1, 1'b0, 8'd3, 35, -1, -1, 1);
    e_ps = rng(0, 35) & ~(rng(3, 6) | rng(11, 14) | rng(19, 22));
    checks++; if (ps_v !== e_ps) begin errors++; $display("FAIL normal_step: got %h want %h", ps_v, e_ps); end
    checks++; if (dn_v !== rng(28, 28)) begin errors++; $display("FAIL normal_done: got %h want %h", dn_v, rng(28, 28)); end
    checks++; if (er_v !== '0) begin errors++; $display("FAIL normal_err: got %h want 0", er_v); end
    checks++; if (by_v !== rng(1, 28)) begin errors++; $display("FAIL normal_busy: got %h want %h", by_v, rng(1, 28)); end
    checks++; if (rd_v !== (rng(0, 0) | rng(29, 35))) begin errors++; $display("FAIL normal_ready: got %h want %h", rd_v, rng(0, 0) | rng(29, 35)); end
    checks++; if (sel1 !== 2'd1 || dir1 !== 1'b0) begin errors++; $display("FAIL normal_seldir: got sel=%0d dir=%b want sel=1 dir=0", sel1, dir1); end
    checks++; if (pos_h[6] !== 4'd0 || pos_h[7] !== 4'd1) begin errors++; $display("FAIL normal_pos_timing: got %0d,%0d want 0,1", pos_h[6], pos_h[7]); end
    checks++; if (pos !== 12'h030) begin errors++; $display("FAIL normal_pos: got %h want 030", pos); end
  endtask

  task automatic test_wrap();
    logic [127:0] e_ps;
    run_req(2'd0, 1'b1, 8'd1, 14, -1, -1, 1);
    checks++; if (dn_v !== rng(12, 12)) begin errors++; $display("FAIL wrap_dec_done: got %h want %h", dn_v, rng(12, 12)); end
    checks++; if (sel1 !== 2'd0 || dir1 !== 1'b1) begin errors++; $display("FAIL wrap_dec_seldir: got sel=%0d dir=%b want sel=0 dir=1", sel1, dir1); end
    checks++; if (pos !== 12'h03f) begin errors++; $display("FAIL wrap_dec_pos: got %h want 03f", pos); end
    run_req(2'd0, 1'b0, 8'd2, 22, -1, -1, 1);
    e_ps = rng(0, 22) & ~(rng(3, 6) | rng(11, 14));
    checks++; if (ps_v !== e_ps) begin errors++; $display("FAIL wrap_inc_step: got %h want %h", ps_v, e_ps); end
    checks++; if (dn_v !== rng(20, 20)) begin errors++; $display("FAIL wrap_inc_done: got %h want %h", dn_v, rng(20, 20)); end
    checks++; if (pos_h[7] !== 4'd0) begin errors++; $display("FAIL wrap_inc_zero: got %0d want 0", pos_h[7]); end
    checks++; if (pos !== 12'h031) begin errors++; $display("FAIL wrap_inc_pos: got %h want 031", pos); end
  endtask

  task automatic test_degenerate();
    run_req(2'd2, 1'b0, 8'd0, 4, -1, -1, 1);
    checks++; if (dn_v !== rng(1, 1) || er_v !== '0) begin errors++; $display("FAIL zero_cnt_pulse: got done=%h err=%h want done=%h err=0", dn_v, er_v, rng(1, 1)); end
    checks++; if (ps_v !== rng(0, 4)) begin errors++; $display("FAIL zero_cnt_step: got %h want %h", ps_v, rng(0, 4)); end
    checks++; if (by_v !== rng(1, 1)) begin errors++; $display("FAIL zero_cnt_busy: got %h want %h", by_v, rng(1, 1)); end
    run_req(2'd3, 1'b0, 8'd5, 4, -1, -1, 1);
    checks++; if (er_v !== rng(1, 1) || dn_v !== '0) begin errors++; $display("FAIL bad_chan_pulse: got err=%h done=%h want err=%h done=0", er_v, dn_v, rng(1, 1)); end
    checks++; if (ps_v !== rng(0, 4)) begin errors++; $display("FAIL bad_chan_step: got %h want %h", ps_v, rng(0, 4)); end
    run_req(2'd0, 1'b0, 8'd2, 4, 0, -1, 1);
    locked = 1'b1;
    checks++; if (er_v !== rng(1, 1) || dn_v !== '0) begin errors++; $display("FAIL unlocked_accept: got err=%h done=%h want err=%h done=0", er_v, dn_v, rng(1, 1)); end
    checks++; if (ps_v !== rng(0, 4)) begin errors++; $display("FAIL unlocked_step: got %h want %h", ps_v, rng(0, 4)); end
    checks++; if (pos !== 12'h031) begin errors++; $display("FAIL degenerate_pos: got %h want 031", pos); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] e_ps;
    run_req(2'd2, 1'b0, 8'd1, 28, -1, -1, 14);
    e_ps = rng(0, 28) & ~(rng(3, 6) | rng(16, 19));
    checks++; if (ps_v !== e_ps) begin errors++; $display("FAIL b2b_step: got %h want %h", ps_v, e_ps); end
    checks++; if (dn_v !== (rng(12, 12) | rng(25, 25))) begin errors++; $display("FAIL b2b_done: got %h want %h", dn_v, rng(12, 12) | rng(25, 25)); end
    checks++; if (by_v !== (rng(1, 12) | rng(14, 25))) begin errors++; $display("FAIL b2b_busy: got %h want %h", by_v, rng(1, 12) | rng(14, 25)); end
    checks++; if (rd_v !== (rng(0, 0) | rng(13, 13) | rng(26, 28))) begin errors++; $display("FAIL b2b_ready: got %h want %h", rd_v, rng(0, 0) | rng(13, 13) | rng(26, 28)); end
    checks++; if (pos !== 12'h231) begin errors++; $display("FAIL b2b_pos: got %h want 231", pos); end
  endtask

  task automatic test_lock_loss();
    run_req(2'd1, 1'b0, 8'd3, 14, 8, -1, 1);
    locked = 1'b1;
    checks++; if (er_v !== rng(9, 9) || dn_v !== '0) begin errors++; $display("FAIL abort_pulse: got err=%h done=%h want err=%h done=0", er_v, dn_v, rng(9, 9)); end
    checks++; if (ps_v !== (rng(0, 14) & ~rng(3, 6))) begin errors++; $display("FAIL abort_step: got %h want %h", ps_v, rng(0, 14) & ~rng(3, 6)); end
    checks++; if (by_v !== rng(1, 9)) begin errors++; $display("FAIL abort_busy: got %h want %h", by_v, rng(1, 9)); end
    checks++; if (pos !== 12'h241) begin errors++; $display("FAIL abort_pos: got %h want 241", pos); end
    run_req(2'd0, 1'b0, 8'd3, 10, 5, -1, 1);
    locked = 1'b1;
    checks++; if (er_v !== rng(6, 6) || dn_v !== '0) begin errors++; $display("FAIL cut_pulse: got err=%h done=%h want err=%h done=0", er_v, dn_v, rng(6, 6)); end
    checks++; if (ps_v !== (rng(0, 10) & ~rng(3, 5))) begin errors++; $display("FAIL cut_step: got %h want %h", ps_v, rng(0, 10) & ~rng(3, 5)); end
    checks++; if (pos !== 12'h241) begin errors++; $display("FAIL cut_pos: got %h want 241", pos); end
  endtask

  task automatic test_timeout();
    run_req(2'd2, 1'b1, 8'd1, 115, 11, -1, 1);
    locked = 1'b1;
    checks++; if (er_v !== rng(111, 111)) begin errors++; $display("FAIL timeout_err: got %h want %h", er_v, rng(111, 111)); end
    checks++; if (dn_v !== '0) begin errors++; $display("FAIL timeout_done: got %h want 0", dn_v); end
    checks++; if (by_v !== rng(1, 111)) begin errors++; $display("FAIL timeout_busy: got %h want %h", by_v, rng(1, 111)); end
    checks++; if (ps_v !== (rng(0, 115) & ~rng(3, 6))) begin errors++; $display("FAIL timeout_step: got %h want %h", ps_v, rng(0, 115) & ~rng(3, 6)); end
    checks++; if (pos !== 12'h141) begin errors++; $display("FAIL timeout_pos: got %h want 141", pos); end
  endtask

  task automatic test_reset_midop();
    run_req(2'd0, 1'b0, 8'd3, 8, -1, 4, 1);
    checks++; if (ps_v !== (rng(0, 8) & ~rng(3, 4))) begin errors++; $display("FAIL midrst_step: got %h want %h", ps_v, rng(0, 8) & ~rng(3, 4)); end
    checks++; if (dn_v !== '0 || er_v !== '0) begin errors++; $display("FAIL midrst_pulse: got done=%h err=%h want 0,0", dn_v, er_v); end
    checks++; if (by_v !== rng(1, 4)) begin errors++; $display("FAIL midrst_busy: got %h want %h", by_v, rng(1, 4)); end
    checks++; if (rd_v !== (rng(0, 0) | rng(6, 8))) begin errors++; $display("FAIL midrst_ready: got %h want %h", rd_v, rng(0, 0) | rng(6, 8)); end
    checks++; if (pos !== 12'h000) begin errors++; $display("FAIL midrst_pos: got %h want 000", pos); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_chan  = 2'd0;
    bus.req_dir   = 1'b0;
    bus.req_count = 8'd0;
    test_reset();
    test_normal();
    test_wrap();
    test_degenerate();
    test_back_to_back();
    test_lock_loss();
    test_timeout();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
